hilo_mac_sequencer: RTL and testbench
=====================================

Name: hilo_mac_sequencer

Overview:
Multi-cycle controller that owns the architectural HI/LO register pair. It sequences the mul, madd and maddu instructions through an iterative shift-add multiplier, replacing a single-cycle 32x32 array multiplier. It also services mthi, mtlo and clear requests. It sits beside alu_top in the execute stage, and the pipeline stalls on op_ready.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
BITS_PER_CYCLE, 2, multiplier bits retired per CALC cycle; must divide DATA_W; legal values 1, 2, 4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  reset; synchronous, active-high.
op_valid  in  1  request present.
op_ready  out  1  sequencer can accept; high only in IDLE.
op_code  in  3  1=MUL, 2=MADD, 3=MADDU, 4=MTHI, 5=MTLO, 6=CLR; 0 and 7 reserved.
rs  in  DATA_W  operand A; the source value for MTHI/MTLO.
rt  in  DATA_W  operand B.
done_valid  out  1  one-cycle completion pulse.
mul_rd  out  DATA_W  low half of the MUL product for rd writeback; valid while done_valid is high.
hi  out  DATA_W  architectural HI.
lo  out  DATA_W  architectural LO.
busy  out  1  equals NOT op_ready.

Behaviour:
- Reset values: hi=0, lo=0, mul_rd=0, done_valid=0, op_ready=1, busy=0, FSM=IDLE.
- Reset mid-operation aborts the operation, discards partial results, clears HI/LO and gives no done pulse.
- Accept occurs on a rising edge where op_valid && op_ready. Operands and op_code are captured at that edge and may change afterwards.
- FSM states: IDLE, CALC.
- IDLE transitions:
  - On accept of MUL/MADD/MADDU, go to CALC with step counter N = DATA_W/BITS_PER_CYCLE.
  - MTHI: hi <= rs at the accept edge; stay in IDLE; done_valid=1 in the following cycle.
  - MTLO: same as MTHI, writing lo.
  - CLR: hi, lo <= 0 at the accept edge; done_valid next cycle.
  - Reserved codes: accepted, no state change, no done pulse.
- Operand preparation at accept:
  - MUL and MADD are signed. Capture |rs| and |rt| plus neg = sign(rs) XOR sign(rt).
  - MADDU is unsigned: neg=0 and raw operands are used.
  - Magnitude of the most negative value (0x80000000) is the unsigned value 2^31; no overflow.
- CALC:
  - Each cycle adds (multiplicand << shift) x the low BITS_PER_CYCLE bits of the multiplier into a 2*DATA_W accumulator.
  - The multiplier shifts right by BITS_PER_CYCLE each cycle; the counter decrements.
  - Leaving CALC on the edge where the counter reaches 1, with product P = neg ? -acc : acc (mod 2^(2*DATA_W)):
    - MUL: {hi,lo} <= P; mul_rd <= P[DATA_W-1:0].
    - MADD/MADDU: {hi,lo} <= {hi,lo} + P, mod 2^(2*DATA_W); carry-out is discarded.
  - The FSM returns to IDLE and done_valid=1 for exactly the next cycle. hi/lo already show the new value in that cycle.
- Latency: for a multiply op accepted at edge t, the result is written at edge t+N and done_valid is high in cycle t+N. With the defaults, N=16.
- Back-to-back: op_ready is high in the same cycle as done_valid, so a new op can be accepted on the next edge with no bubble.
- op_valid while busy: not accepted; the requester must hold the request. No queuing.
- HI/LO are never written during CALC; external reads see the old value until completion.
- mul_rd holds its last value until the next MUL completes.

Decomposition:
- Package alu_seq_pkg holds:
  - the op_code enumeration (OP_MUL..OP_CLR);
  - the FSM state typedef;
  - the DATA_W default;
  - a step-count constant function.
- One combinational sub-module, mul_step, computes the next accumulator value from acc, multiplicand, multiplier bits and shift. The top level holds the FSM, counter, operand registers and HI/LO.

Test Plan:
1. Reset, then MUL rs=-3 (0xFFFFFFFD), rt=5 -> after 16 cycles done_valid pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFF1, mul_rd=0xFFFFFFF1.
2. From the state of scenario 1, MADD rs=4, rt=4 -> hi=0x00000000, lo=0x00000001, since -15+16=1 with carry into HI.
3. CLR, then MADDU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a following MUL rs=0x80000000, rt=-1 gives hi=0x00000000, lo=0x80000000.
4. MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> each gets a done pulse one cycle after accept; hi/lo hold the written values.
5. Assert op_valid with MTLO throughout a MUL -> op_ready=0 and lo unchanged during CALC; MTLO is accepted the cycle done_valid pulses; final lo equals the MTLO operand.
6. Assert reset at CALC cycle 7 of a MUL -> next cycle hi=lo=0, op_ready=1, and no done_valid ever appears for the aborted op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the HI/LO multiply-accumulate sequencer.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_RSVD0 = 3'd0,
        OP_MUL   = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_CLR   = 3'd6,
        OP_RSVD7 = 3'd7
    } op_code_e;

    typedef enum logic {
        ST_IDLE,
        ST_CALC
    } state_e;

    // Number of CALC cycles needed to retire every multiplier bit.
    function automatic int step_count(input int data_w, input int bits_per_cycle);
        return data_w / bits_per_cycle;
    endfunction

endpackage

// File: rtl/hilo_mac_sequencer_mul_step.sv
// One shift-add iteration: folds BPC multiplier bits into the 2*DATA_W accumulator.
module mul_step
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BPC    = 2,
    parameter int SW     = $clog2(DATA_W)
) (
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0]   mcand_i,
    input  logic [BPC-1:0]      bits_i,
    input  logic [SW-1:0]       shift_i,
    output logic [2*DATA_W-1:0] acc_o
);

    logic [2*DATA_W-1:0] mcand_ext;

    assign mcand_ext = {{DATA_W{1'b0}}, mcand_i};

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < BPC; i++) begin
            if (bits_i[i]) begin
                acc_o = acc_o + (mcand_ext << (32'(shift_i) + i));
            end
        end
    end

endmodule

// File: rtl/hilo_mac_sequencer.sv
// Owns HI/LO; runs mul/madd/maddu through an iterative shift-add multiplier
// and services mthi/mtlo/clr in a single cycle.
module hilo_mac_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              done_valid,
    output logic [DATA_W-1:0] mul_rd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);

    localparam int N  = step_count(DATA_W, BITS_PER_CYCLE);
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(DATA_W);
    localparam int AW = 2 * DATA_W;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              accum_q, accum_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] mul_rd_q, mul_rd_d;
    logic              done_q, done_d;

    op_code_e          op;
    logic              accept;
    logic [DATA_W-1:0] rs_mag, rt_mag;
    logic [AW-1:0]     acc_nxt, prod, sum;

    assign op       = op_code_e'(op_code);
    assign op_ready = (state_q == ST_IDLE);
    assign busy     = ~op_ready;
    assign accept   = op_valid && op_ready;

    // Negating 0x80..0 yields 0x80..0, which read unsigned is exactly 2^(W-1).
    assign rs_mag = rs[DATA_W-1] ? -rs : rs;
    assign rt_mag = rt[DATA_W-1] ? -rt : rt;

    mul_step #(
        .DATA_W (DATA_W),
        .BPC    (BITS_PER_CYCLE),
        .SW     (SW)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
        .shift_i (shift_q),
        .acc_o   (acc_nxt)
    );

    assign prod = neg_q ? -acc_nxt : acc_nxt;
    assign sum  = {hi_q, lo_q} + prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        accum_d  = accum_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_rd_d = mul_rd_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_MUL, OP_MADD, OP_MADDU: begin
                            state_d = ST_CALC;
                            cnt_d   = CW'(N);
                            shift_d = '0;
                            acc_d   = '0;
                            accum_d = (op != OP_MUL);
                            if (op == OP_MADDU) begin
                                neg_d    = 1'b0;
                                mcand_d  = rs;
                                mplier_d = rt;
                            end else begin
                                neg_d    = rs[DATA_W-1] ^ rt[DATA_W-1];
                                mcand_d  = rs_mag;
                                mplier_d = rt_mag;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = rs;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = rs;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            hi_d   = '0;
                            lo_d   = '0;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                acc_d    = acc_nxt;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                shift_d  = shift_q + SW'(BITS_PER_CYCLE);
                cnt_d    = cnt_q - 1'b1;
                // Final step: HI/LO are only touched here, never mid-CALC.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (accum_q) begin
                        {hi_d, lo_d} = sum;
                    end else begin
                        {hi_d, lo_d} = prod;
                        mul_rd_d     = prod[DATA_W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            accum_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mul_rd_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            accum_q  <= accum_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mul_rd_q <= mul_rd_d;
            done_q   <= done_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_rd     = mul_rd_q;
    assign done_valid = done_q;

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
// Directed vector bench for hilo_mac_sequencer (DATA_W=32, BITS_PER_CYCLE=2).
module tb_hilo_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [31:0] rs, rt;
    logic        done_valid;
    logic [31:0] mul_rd, hi, lo;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    hilo_mac_sequencer #(.DATA_W(32), .BITS_PER_CYCLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .rs         (rs),
        .rt         (rt),
        .done_valid (done_valid),
        .mul_rd     (mul_rd),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_rd;
        int          exp_lat; // negedges after accept until done; 0 = never
    } vec_t;

    localparam int NV = 14;
    localparam int MLAT = 17; // 16 CALC steps, done seen one sample later

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic        hold_ok;
        logic [31:0] h0, l0;
        lat     = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        chk({v.name, "_ready"}, 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_code  = v.op;
        rs       = v.rs;
        rt       = v.rt;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        rs       = $urandom;
        rt       = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_valid) begin
                lat = c;
                break;
            end
            if (v.exp_lat > 1 && (op_ready !== 1'b0 || busy !== 1'b1 || hi !== h0 || lo !== l0))
                hold_ok = 1'b0;
            if (v.exp_lat == 0 && c == 20) break;
        end
        chk({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
        if (v.exp_lat > 1) chk({v.name, "_calc_hold"}, 32'(hold_ok), 32'd1);
        chk({v.name, "_hi"}, hi, v.exp_hi);
        chk({v.name, "_lo"}, lo, v.exp_lo);
        chk({v.name, "_rd"}, mul_rd, v.exp_rd);
        @(negedge clk);
        chk({v.name, "_done_drop"}, 32'(done_valid), 32'd0);
    endtask

    vec_t tbl [NV];

    initial begin
        int lat;
        logic ok;

        tbl[0]  = '{"mul_m3x5",    3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFF1, MLAT};
        tbl[1]  = '{"madd_4x4",    3'd2, 32'h00000004, 32'h00000004, 32'h00000000, 32'h00000001, 32'hFFFFFFF1, MLAT};
        tbl[2]  = '{"clr",         3'd6, 32'h0BADF00D, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFF1, 1};
        tbl[3]  = '{"maddu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFF1, MLAT};
        tbl[4]  = '{"mul_min_m1",  3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000, MLAT};
        tbl[5]  = '{"rsvd7",       3'd7, 32'h11111111, 32'h22222222, 32'h00000000, 32'h80000000, 32'h80000000, 0};
        tbl[6]  = '{"rsvd0",       3'd0, 32'h33333333, 32'h44444444, 32'h00000000, 32'h80000000, 32'h80000000, 0};
        tbl[7]  = '{"mul_m7xm6",   3'd1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A, 32'h0000002A, MLAT};
        tbl[8]  = '{"madd_maxpos", 3'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h0000002B, 32'h0000002A, MLAT};
        tbl[9]  = '{"madd_m1x1",   3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h0000002A, 32'h0000002A, MLAT};
        tbl[10] = '{"maddu_2p32",  3'd3, 32'h80000000, 32'h00000002, 32'h40000000, 32'h0000002A, 32'h0000002A, MLAT};
        tbl[11] = '{"mtlo",        3'd5, 32'h55AA55AA, 32'h00000000, 32'h40000000, 32'h55AA55AA, 32'h0000002A, 1};
        tbl[12] = '{"madd_minmin", 3'd2, 32'h80000000, 32'h80000000, 32'h80000000, 32'h55AA55AA, 32'h0000002A, MLAT};
        tbl[13] = '{"mul_2p32",    3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00000000, MLAT};

        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        rs       = '0;
        rt       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi",    hi, 32'h0);
        chk("rst_lo",    lo, 32'h0);
        chk("rst_rd",    mul_rd, 32'h0);
        chk("rst_done",  32'(done_valid), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(tbl[i]);

        // MTHI then MTLO on consecutive edges, each pulsing done the next cycle.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd4; rs = 32'h12345678;
        @(posedge clk);
        #1;
        op_code = 3'd5; rs = 32'h9ABCDEF0;
        @(negedge clk);
        chk("b2b_mthi_done", 32'(done_valid), 32'd1);
        chk("b2b_mthi_hi",   hi, 32'h12345678);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("b2b_mtlo_done", 32'(done_valid), 32'd1);
        chk("b2b_mtlo_lo",   lo, 32'h9ABCDEF0);
        chk("b2b_mtlo_hi",   hi, 32'h12345678);
        @(negedge clk);
        chk("b2b_done_drop", 32'(done_valid), 32'd0);

        // MTLO held valid across a MUL: must wait, then be taken the done cycle.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd1; rs = 32'd3; rt = 32'd7;
        @(posedge clk);
        #1;
        op_code = 3'd5; rs = 32'hCAFEF00D;
        lat = 0;
        ok  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_valid) begin
                lat = c;
                break;
            end
            if (op_ready !== 1'b0 || lo !== 32'h9ABCDEF0) ok = 1'b0;
        end
        chk("hold_lat",      32'(lat), 32'(MLAT));
        chk("hold_calc",     32'(ok), 32'd1);
        chk("hold_mul_lo",   lo, 32'd21);
        chk("hold_ready",    32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("hold_mtlo_done", 32'(done_valid), 32'd1);
        chk("hold_mtlo_lo",   lo, 32'hCAFEF00D);
        chk("hold_mtlo_hi",   hi, 32'h0);

        // Reset in CALC cycle 7 aborts with no completion pulse.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd1; rs = 32'd5; rt = 32'hFFFFFFFB;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_hi",    hi, 32'h0);
        chk("abort_lo",    lo, 32'h0);
        chk("abort_rd",    mul_rd, 32'h0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_valid !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_done", 32'(ok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
